// File: rtl/arbiter_iwrr_cfg.sv
// arbiter_iwrr_cfg: interleaved weighted round-robin arbiter with shadowed, round-aligned weight reload
module arbiter_iwrr_cfg #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W = 4,
  parameter logic [P_WEIGHT_W-1:0] P_REQUESTER_WEIGHT [P_REQUESTER_NUM] = '{4'd5, 4'd3, 4'd2}
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [P_REQUESTER_NUM-1:0]              request,
  input  logic                                    grant_ready,
  output logic [P_REQUESTER_NUM-1:0]              grant_valid,
  output logic [$clog2(P_REQUESTER_NUM)-1:0]      grant_idx,
  input  logic                                    cfg_valid,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0]   cfg_weight,
  output logic                                    cfg_pending
);
  localparam int N = P_REQUESTER_NUM;
  localparam int W = P_WEIGHT_W;
  localparam int IW = $clog2(N);
  localparam int RW = W + 1;

  logic [W-1:0]    r_wt [N];
  logic [N*W-1:0]  r_shadow;
  logic            r_pend;
  logic [RW-1:0]   r_rnd;
  logic [IW-1:0]   r_ptr;
  logic [N-1:0]    r_gv;
  logic [IW-1:0]   r_gi;
  logic [RW-1:0]   w_max, w_rn, w_rnd_g, w_rnd_n;
  logic [N-1:0]    w_e1, w_e2, w_e3;
  logic [IW-1:0]   w_k, w_ptr_n;
  logic            w_hit, w_last, w_wrap, w_eval, w_apply;

  function automatic logic [IW-1:0] f_lo(input logic [N-1:0] v);
    f_lo = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) f_lo = IW'(i);
  endfunction

  always_comb begin
    w_max = '0;
    for (int i = 0; i < N; i++) begin
      w_max = ({1'b0, r_wt[i]} > w_max) ? {1'b0, r_wt[i]} : w_max;
      w_e1[i] = request[i] && {1'b0, r_wt[i]} >= r_rnd && i >= int'(r_ptr);
      w_e3[i] = request[i] && r_wt[i] != '0;
    end
    w_rn = (r_rnd >= w_max) ? RW'(1) : r_rnd + RW'(1);
    for (int i = 0; i < N; i++) w_e2[i] = request[i] && {1'b0, r_wt[i]} >= w_rn;
  end

  // e1 and e2 are subsets of e3, so e3 alone decides whether anything is granted
  always_comb begin
    w_hit = |w_e3;
    w_k = |w_e1 ? f_lo(w_e1) : |w_e2 ? f_lo(w_e2) : f_lo(w_e3);
    w_rnd_g = |w_e1 ? r_rnd : |w_e2 ? w_rn : RW'(1);
    w_last = w_k == IW'(N - 1);
    w_ptr_n = w_last ? '0 : w_k + IW'(1);
    w_rnd_n = !w_last ? w_rnd_g : (w_rnd_g >= w_max) ? RW'(1) : w_rnd_g + RW'(1);
    w_wrap = (!(|w_e1) && |w_e2 && w_rn == RW'(1)) || (w_last && w_rnd_g >= w_max);
    w_eval = !(|r_gv) || grant_ready;
    w_apply = r_pend && ((w_eval && w_hit && w_wrap) || (!(|r_gv) && !(|request)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gv <= '0;
      r_gi <= '0;
      r_rnd <= RW'(1);
      r_ptr <= '0;
      r_shadow <= '0;
      r_pend <= 1'b0;
      for (int i = 0; i < N; i++) r_wt[i] <= P_REQUESTER_WEIGHT[i];
    end else begin
      if (w_eval) begin
        r_gv <= w_hit ? N'(1) << w_k : '0;
        r_gi <= w_hit ? w_k : '0;
      end
      if (w_apply) begin
        r_rnd <= RW'(1);
        r_ptr <= '0;
        for (int i = 0; i < N; i++) r_wt[i] <= r_shadow[i*W +: W];
      end else if (w_eval && w_hit) begin
        r_rnd <= w_rnd_n;
        r_ptr <= w_ptr_n;
      end
      if (cfg_valid) r_shadow <= cfg_weight;
      r_pend <= cfg_valid || (r_pend && !w_apply);
    end
  end

  assign grant_valid = r_gv;
  assign grant_idx = r_gi;
  assign cfg_pending = r_pend;
endmodule

// File: tb/tb_arbiter_iwrr_cfg.sv
// tb_arbiter_iwrr_cfg: vector-table and scoreboard bench for the weighted round-robin arbiter
module tb_arbiter_iwrr_cfg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  request;
  logic        grant_ready;
  logic [2:0]  grant_valid;
  logic [1:0]  grant_idx;
  logic        cfg_valid;
  logic [11:0] cfg_weight;
  logic        cfg_pending;

  arbiter_iwrr_cfg dut (
    .clk(clk), .rst_n(rst_n), .request(request), .grant_ready(grant_ready),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .cfg_valid(cfg_valid),
    .cfg_weight(cfg_weight), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic        rdy;
    logic        cfgv;
    logic [11:0] cfgw;
    logic [2:0]  gv;
    logic [1:0]  gi;
    logic        pend;
  } vec_t;

  typedef struct {
    logic [2:0] gv;
    logic [1:0] gi;
    logic       pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int row = 0;

  function automatic vec_t mk(input logic rn, input logic [2:0] req, input logic rdy,
                              input logic cfgv, input logic [11:0] cfgw, input byte g, input logic p);
    vec_t v;
    int d;
    d = int'(g) - 48;
    v.rst_n = rn;
    v.req = req;
    v.rdy = rdy;
    v.cfgv = cfgv;
    v.cfgw = cfgw;
    v.gv = (g == "-") ? 3'b000 : 3'(1 << d);
    v.gi = (g == "-") ? 2'd0 : 2'(d);
    v.pend = p;
    return v;
  endfunction

  task automatic add(input logic rn, input logic [2:0] req, input logic rdy, input logic cfgv,
                     input logic [11:0] cfgw, input string g, input string p);
    for (int i = 0; i < g.len(); i++)
      tbl.push_back(mk(rn, req, rdy, cfgv && i == 0, cfgw, g[i], p[(p.len() == 1) ? 0 : i] == "1"));
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    rst_n = v.rst_n;
    request = v.req;
    grant_ready = v.rdy;
    cfg_valid = v.cfgv;
    cfg_weight = v.cfgw;
    e.gv = v.gv;
    e.gi = v.gi;
    e.pend = v.pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant_valid", {1'b0, grant_valid}, {1'b0, e.gv});
    chk("grant_idx", {2'b0, grant_idx}, {2'b0, e.gi});
    chk("cfg_pending", {3'b0, cfg_pending}, {3'b0, e.pend});
    row++;
  endtask

  initial begin
    string s;
    rst_n = 1'b0;
    request = '0;
    grant_ready = 1'b0;
    cfg_valid = 1'b0;
    cfg_weight = '0;
    // reset, then default weights 5,3,2 with everyone requesting
    add(0, 3'b111, 1, 0, 12'h000, "--", "0");
    add(1, 3'b111, 1, 0, 12'h000, "01201201000120120100", "0");
    // stall with grant 1 shown while request[1] drops, then resume from ptr 2
    add(1, 3'b111, 1, 0, 12'h000, "01", "0");
    add(1, 3'b101, 0, 0, 12'h000, "11111", "0");
    add(1, 3'b101, 1, 0, 12'h000, "2020", "0");
    // single requester, then requesters 1 and 2 only
    add(1, 3'b001, 1, 0, 12'h000, "0000", "0");
    add(1, 3'b110, 1, 0, 12'h000, "1211212112", "0");
    // load {1,1,4} mid-round: held off until the round wraps
    add(1, 3'b111, 1, 1, 12'h411, "01201000", "11111110");
    add(1, 3'b111, 1, 0, 12'h000, "012222012222", "0");
    // load {0,2,0}, then a new load on the apply edge keeps pending set
    add(1, 3'b111, 1, 1, 12'h020, "01222", "1");
    add(1, 3'b111, 1, 1, 12'h000, "2", "1");
    add(1, 3'b111, 1, 0, 12'h000, "111---", "110000");
    // all-zero weights: reload only applies once idle with no requests
    add(1, 3'b111, 1, 1, 12'h235, "--", "1");
    add(1, 3'b000, 1, 0, 12'h000, "-", "0");
    add(1, 3'b111, 1, 0, 12'h000, "012", "0");
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    // reset pulse mid-sequence drops the grant and the pending reload
    step(mk(1, 3'b111, 1, 1, 12'h111, "0", 1));
    step(mk(0, 3'b111, 1, 0, 12'h000, "-", 0));
    s = "0120120100";
    for (int i = 0; i < s.len(); i++) step(mk(1, 3'b111, 1, 0, 12'h000, s[i], 0));
    // a held grant survives a reload; the reload lands on the next wrap
    step(mk(1, 3'b111, 0, 1, 12'h000, "0", 1));
    step(mk(1, 3'b111, 0, 0, 12'h000, "0", 1));
    step(mk(1, 3'b111, 0, 0, 12'h000, "0", 1));
    step(mk(1, 3'b111, 1, 0, 12'h000, "0", 0));
    step(mk(1, 3'b111, 1, 0, 12'h000, "-", 0));
    step(mk(1, 3'b111, 1, 0, 12'h000, "-", 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbiter_iwrr_cfg.md
ARBITER_IWRR_CFG -- requirements
Module: arbiter_iwrr_cfg

Interface
REQ-001 SHALL provide parameter P_REQUESTER_NUM, default 3, number of requesters (2..32).
REQ-002 SHALL provide parameter P_WEIGHT_W, default 4, bit width of each weight.
REQ-003 SHALL provide parameter P_REQUESTER_WEIGHT, default {5,3,2}, per-requester reset weight; element i belongs to requester i.
REQ-004 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port request  input  P_REQUESTER_NUM  bit i = requester i wants service.
REQ-007 SHALL provide port grant_ready  input  1  consumer accepts the current grant.
REQ-008 SHALL provide port grant_valid  output  P_REQUESTER_NUM  registered one-hot grant, or all-zero.
REQ-009 SHALL provide port grant_idx  output  $clog2(P_REQUESTER_NUM)  registered binary index of the granted requester; 0 when there is no grant.
REQ-010 SHALL provide port cfg_valid  input  1  single-cycle pulse that loads new weights.
REQ-011 SHALL provide port cfg_weight  input  P_REQUESTER_NUM*P_WEIGHT_W  new weights; requester i uses bits [i*P_WEIGHT_W +: P_WEIGHT_W].
REQ-012 SHALL provide port cfg_pending  output  1  high while loaded weights wait to be applied.

Function
REQ-013 Weight 0 SHALL exclude a requester from all grants.
REQ-014 State: active weights wt[i], round counter rnd (1..max_wt), pointer ptr (0..N-1), where max_wt is the maximum of the active wt[].
REQ-015 Handshake fires when grant_valid != 0 and grant_ready = 1.
REQ-016 Arbitration SHALL evaluate only when grant_valid = 0 or the handshake fires; the result loads grant_valid/grant_idx at the same edge, giving one grant per cycle under continuous ready.
REQ-017 While grant_valid != 0 and grant_ready = 0, grant_valid, grant_idx, rnd and ptr SHALL hold, even if the granted request deasserts.
REQ-018 Step 1: E1 = request & (wt >= rnd) & (index >= ptr). If E1 is non-empty, grant its lowest index k and keep rnd.
REQ-019 Step 2: if E1 is empty, set rn = (rnd >= max_wt) ? 1 : rnd+1 and E2 = request & (wt >= rn). If E2 is non-empty, grant its lowest index k and set rnd = rn.
REQ-020 Step 3: if E2 is also empty, grant the lowest index k of request & (wt != 0) and set rnd = 1. If that set is empty, there is no grant: grant_valid = 0 and rnd and ptr hold.
REQ-021 After any grant to k: ptr = k+1. If k+1 = N, ptr = 0 and rnd advances as in REQ-019.
REQ-022 The round arithmetic SHALL use P_WEIGHT_W+1 bits so that rnd+1 cannot overflow when a weight is at its maximum.
REQ-023 When cfg_valid = 1, cfg_weight SHALL be captured into a shadow register and cfg_pending set the next cycle. A later cfg_valid overwrites the shadow.
REQ-024 Shadow weights SHALL be applied, and cfg_pending cleared, at the first edge where either:
  - rnd wraps to 1 (REQ-019 or REQ-021), or
  - grant_valid = 0 and request = 0.
  On that edge rnd = 1 and ptr = 0 take effect with the new weights.
REQ-025 cfg_valid on the same edge as an apply SHALL be captured into the shadow, and cfg_pending SHALL stay set.
REQ-026 A held grant (REQ-017) SHALL NOT be revoked by a weight change.
REQ-027 With all active weights zero, grant_valid SHALL stay 0.
REQ-028 There SHALL be no combinational path from inputs to outputs.

Reset
REQ-029 When rst_n = 0 at a clock edge: grant_valid = 0, grant_idx = 0, rnd = 1, ptr = 0, wt[i] = P_REQUESTER_WEIGHT[i], shadow cleared, cfg_pending = 0.
REQ-030 Reset asserted mid-grant SHALL drop the grant at that edge; the first grant after rst_n rises SHALL appear one cycle after request is sampled.

Verification
REQ-031 Defaults, request = 3'b111, grant_ready = 1 -> grant_idx sequence 0,1,2,0,1,2,0,1,0,0, repeating every 10 cycles; first grant 1 cycle after reset release.
REQ-032 request = 3'b001 only -> grant 0 every cycle. Then request = 3'b110 -> sequence 1,2,1,2,1 per period (weights 3,2).
REQ-033 grant_ready low for 5 cycles with grant_idx = 1 and request[1] dropped -> grant_valid = 3'b010 held; on ready the sequence continues from ptr = 2.
REQ-034 cfg_valid with weights {1,1,4} mid-round -> cfg_pending = 1 until rnd wraps; then sequence 0,1,2,2,2,2 repeating.
REQ-035 Weights {0,2,0}, request = 3'b111 -> only grant 1, every cycle. All weights 0 -> grant_valid stays 0.
REQ-036 rst_n pulsed low for 1 cycle mid-sequence -> outputs zero at that edge; sequence restarts at 0 with the P_REQUESTER_WEIGHT weights.
